// File: rtl/display_scanner.sv
// display_scanner: scans one 32-bit debug word as 8 hex digits on a
// common-anode display. SCAN_LEADING_ZERO_BLANK_EN enables zero blanking.
module display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] displayV0,
    input  logic [31:0] displayV1,
    input  logic        BtnNext,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        Page
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [31:0]   shadow;
    logic          s1, s2, s3;

    logic          slotEnd;
    logic          frameEnd;
    logic          btnRise;
    logic [3:0]    nibble;
    logic          blanking;
    logic          markDig;
    logic          digitOn;
    logic [7:0]    anNext;
    logic [6:0]    segNext;
    logic          dpNext;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slotEnd  = (div == DIV_LAST);
    assign frameEnd = slotEnd && (idx == 3'd7);
    assign btnRise  = s2 & ~s3;

`ifdef SCAN_LEADING_ZERO_BLANK_EN
    logic [2:0] topNib;

    // Highest nonzero nibble of the frame word; 0 when the word is 0.
    always_comb begin
        topNib = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (shadow[4*k +: 4] != 4'h0) topNib = 3'(k);
        end
    end

    assign digitOn = (idx <= topNib);
`else
    assign digitOn = 1'b1;
`endif

    // Next-cycle drive for anodes, cathodes and decimal point.
    always_comb begin
        nibble   = shadow[{idx, 2'b00} +: 4];
        blanking = (int'(div) < BLANK);
        markDig  = (idx == 3'd7) && Page;
        anNext   = 8'hFF;
        segNext  = 7'h7F;
        if (digitOn) segNext = hexSeg(nibble);
        if (!blanking && (digitOn || markDig)) anNext[idx] = 1'b0;
        dpNext = ~(!blanking && markDig);
    end

    // Slot divider, digit index and per-frame snapshot.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div    <= '0;
            idx    <= 3'd0;
            shadow <= 32'd0;
        end else begin
            div <= slotEnd ? '0 : div + 1'b1;
            if (slotEnd) idx <= idx + 3'd1;
            if (frameEnd) shadow <= Page ? displayV1 : displayV0;
        end
    end

    // Button synchronizer and edge-triggered page toggle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            Page <= 1'b0;
        end else begin
            s1 <= BtnNext;
            s2 <= s1;
            s3 <= s2;
            if (btnRise) Page <= ~Page;
        end
    end

    // Registered display outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= anNext;
            seg <= segNext;
            dp  <= dpNext;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed frame-by-frame checks of display_scanner
// with REFRESH_DIV=4, BLANK=1 (32-cycle frames).
module tb_display_scanner;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] displayV0;
    logic [31:0] displayV1;
    logic        BtnNext;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        Page;

    int nTests = 0;
    int nFail  = 0;
    int frameNo = 0;
    logic expPage = 1'b0;

    logic [6:0] hexTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    display_scanner #(.REFRESH_DIV(4), .BLANK(1)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .displayV0(displayV0),
        .displayV1(displayV1),
        .BtnNext(BtnNext),
        .an(an),
        .seg(seg),
        .dp(dp),
        .Page(Page)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One 32-cycle frame showing word; optional button window.
    task automatic runFrame(input logic [31:0] word, input int pAt,
                            input int pLen);
        int slot, ph, top;
        logic pgBefore, lit, anLit;
        logic [7:0] eAn;
        logic [6:0] eSeg;
        frameNo++;
        top = 0;
        for (int k = 1; k < 8; k++)
            if (word[4*k +: 4] != 4'h0) top = k;
        for (int c = 1; c <= 32; c++) begin
            tick();
            BtnNext = (pLen > 0) && (c >= pAt) && (c < pAt + pLen);
            pgBefore = expPage;
            if (pLen > 0 && c == pAt + 3) expPage = ~expPage;
            slot = (c - 1) / 4;
            ph   = (c - 1) % 4;
`ifdef SCAN_LEADING_ZERO_BLANK_EN
            lit = (slot <= top);
`else
            lit = 1'b1;
`endif
            anLit = lit || (slot == 7 && pgBefore);
            eSeg = lit ? hexTab[word[4*slot +: 4]] : 7'h7F;
            eAn  = 8'hFF;
            if (ph >= 1 && anLit) eAn = ~(8'h01 << slot);
            chk($sformatf("an f%0d c%0d", frameNo, c), 32'(an), 32'(eAn));
            chk($sformatf("seg f%0d c%0d", frameNo, c), 32'(seg),
                32'(eSeg));
            chk($sformatf("dp f%0d c%0d", frameNo, c), 32'(dp),
                32'(!(ph >= 1 && slot == 7 && pgBefore)));
            chk($sformatf("page f%0d c%0d", frameNo, c), 32'(Page),
                32'(expPage));
        end
    endtask

    initial begin
        Reset     = 1'b0;
        displayV0 = 32'd0;
        displayV1 = 32'd0;
        BtnNext   = 1'b0;
        repeat (3) tick();
        chk("rst an", 32'(an), 32'hFF);
        chk("rst seg", 32'(seg), 32'h7F);
        chk("rst dp", 32'(dp), 32'h1);
        chk("rst page", 32'(Page), 32'h0);

        displayV0 = 32'h12345678;
        displayV1 = 32'hDEADBEEF;
        Reset = 1'b1;

        runFrame(32'h0, 0, 0);
        runFrame(32'h12345678, 0, 0);
        runFrame(32'h12345678, 5, 1);
        runFrame(32'hDEADBEEF, 0, 0);
        runFrame(32'hDEADBEEF, 2, 20);
        runFrame(32'h12345678, 4, 1);
        runFrame(32'hDEADBEEF, 29, 1);
        runFrame(32'hDEADBEEF, 0, 0);
        displayV0 = 32'h9ABCDEF0;
        runFrame(32'h12345678, 0, 0);
        runFrame(32'h9ABCDEF0, 3, 1);

        repeat (6) tick();
        #2 Reset = 1'b0;
        #1;
        chk("midrst an", 32'(an), 32'hFF);
        chk("midrst seg", 32'(seg), 32'h7F);
        chk("midrst dp", 32'(dp), 32'h1);
        chk("midrst page", 32'(Page), 32'h0);
        expPage = 1'b0;
        displayV0 = 32'h000000A5;
        tick();
        tick();
        chk("rsthold an", 32'(an), 32'hFF);
        Reset = 1'b1;

        runFrame(32'h0, 0, 0);
        runFrame(32'h000000A5, 0, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
